// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback bypass, load-use hazard stall/bubble
// insertion, branch flush, and a saturating stall-bubble counter.
module id_ex_stage #(
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              startin,
    input  logic              valid_id,
    input  logic [4:0]        rs_id,
    input  logic [4:0]        rt_id,
    input  logic              uses_rt_id,
    input  logic [4:0]        write_reg_id,
    input  logic [31:0]       data1_id,
    input  logic [31:0]       data2_id,
    input  logic [31:0]       imm_id,
    input  logic              reg_write_id,
    input  logic              mem_read_id,
    input  logic [CTRL_W-1:0] ctrl_id,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [31:0]       wb_write_data,
    input  logic              flush,
    output logic              stall_out,
    output logic              valid_ex,
    output logic              reg_write_ex,
    output logic              mem_read_ex,
    output logic [CTRL_W-1:0] ctrl_ex,
    output logic [4:0]        rs_ex,
    output logic [4:0]        rt_ex,
    output logic [4:0]        write_reg_ex,
    output logic [31:0]       a_ex,
    output logic [31:0]       b_ex,
    output logic [31:0]       imm_ex,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [31:0] a_next;
    logic [31:0] b_next;
    logic        hz;
    logic        wb_live;

    // Register file writes at the edge but reads asynchronously, so same-cycle
    // writeback data has to be steered in here; r0 is never bypassed.
    always_comb begin
        wb_live = wb_reg_write && (wb_write_reg != 5'd0);
        a_next  = (wb_live && (wb_write_reg == rs_id)) ? wb_write_data : data1_id;
        b_next  = (wb_live && (wb_write_reg == rt_id)) ? wb_write_data : data2_id;
    end

    always_comb begin
        hz = valid_ex && mem_read_ex && (write_reg_ex != 5'd0) && valid_id &&
             ((write_reg_ex == rs_id) || (uses_rt_id && (write_reg_ex == rt_id)));
        stall_out = hz && !flush && !startin;
    end

    always_ff @(posedge clk) begin
        if (startin || flush || hz) begin
            valid_ex     <= 1'b0;
            reg_write_ex <= 1'b0;
            mem_read_ex  <= 1'b0;
            ctrl_ex      <= '0;
            rs_ex        <= '0;
            rt_ex        <= '0;
            write_reg_ex <= '0;
            a_ex         <= '0;
            b_ex         <= '0;
            imm_ex       <= '0;
        end else begin
            valid_ex     <= valid_id;
            reg_write_ex <= valid_id && reg_write_id;
            mem_read_ex  <= valid_id && mem_read_id;
            ctrl_ex      <= valid_id ? ctrl_id : '0;
            rs_ex        <= rs_id;
            rt_ex        <= rt_id;
            write_reg_ex <= write_reg_id;
            a_ex         <= a_next;
            b_ex         <= b_next;
            imm_ex       <= imm_id;
        end
    end

    // Only load-use bubbles are counted; flush bubbles take priority and are not.
    always_ff @(posedge clk) begin
        if (startin) begin
            bubble_cnt <= '0;
        end else if (!flush && hz && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a
// 2-bit counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        startin;
    logic        valid_id;
    logic [4:0]  rs_id, rt_id, write_reg_id, wb_write_reg;
    logic        uses_rt_id, reg_write_id, mem_read_id, wb_reg_write, flush;
    logic [31:0] data1_id, data2_id, imm_id, wb_write_data;
    logic [7:0]  ctrl_id;

    logic        stall_out, valid_ex, reg_write_ex, mem_read_ex;
    logic [7:0]  ctrl_ex;
    logic [4:0]  rs_ex, rt_ex, write_reg_ex;
    logic [31:0] a_ex, b_ex, imm_ex;
    logic [15:0] bubble_cnt;

    logic        s_stall_out, s_valid_ex, s_reg_write_ex, s_mem_read_ex;
    logic [7:0]  s_ctrl_ex;
    logic [4:0]  s_rs_ex, s_rt_ex, s_write_reg_ex;
    logic [31:0] s_a_ex, s_b_ex, s_imm_ex;
    logic [1:0]  s_bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
        .clk(clk), .startin(startin), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .write_reg_id(write_reg_id), .data1_id(data1_id),
        .data2_id(data2_id), .imm_id(imm_id), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .ctrl_id(ctrl_id), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
        .stall_out(stall_out), .valid_ex(valid_ex), .reg_write_ex(reg_write_ex),
        .mem_read_ex(mem_read_ex), .ctrl_ex(ctrl_ex), .rs_ex(rs_ex), .rt_ex(rt_ex),
        .write_reg_ex(write_reg_ex), .a_ex(a_ex), .b_ex(b_ex), .imm_ex(imm_ex),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_stage #(.CTRL_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .startin(startin), .valid_id(valid_id), .rs_id(rs_id), .rt_id(rt_id),
        .uses_rt_id(uses_rt_id), .write_reg_id(write_reg_id), .data1_id(data1_id),
        .data2_id(data2_id), .imm_id(imm_id), .reg_write_id(reg_write_id),
        .mem_read_id(mem_read_id), .ctrl_id(ctrl_id), .wb_reg_write(wb_reg_write),
        .wb_write_reg(wb_write_reg), .wb_write_data(wb_write_data), .flush(flush),
        .stall_out(s_stall_out), .valid_ex(s_valid_ex), .reg_write_ex(s_reg_write_ex),
        .mem_read_ex(s_mem_read_ex), .ctrl_ex(s_ctrl_ex), .rs_ex(s_rs_ex), .rt_ex(s_rt_ex),
        .write_reg_ex(s_write_reg_ex), .a_ex(s_a_ex), .b_ex(s_b_ex), .imm_ex(s_imm_ex),
        .bubble_cnt(s_bubble_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        startin = 1'b0; valid_id = 1'b0; rs_id = '0; rt_id = '0; uses_rt_id = 1'b0;
        write_reg_id = '0; data1_id = '0; data2_id = '0; imm_id = '0;
        reg_write_id = 1'b0; mem_read_id = 1'b0; ctrl_id = '0;
        wb_reg_write = 1'b0; wb_write_reg = '0; wb_write_data = '0; flush = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] dst);
        drive_idle();
        valid_id = 1'b1; rs_id = 5'd1; write_reg_id = dst;
        reg_write_id = 1'b1; mem_read_id = 1'b1; imm_id = 32'd4;
    endtask

    task automatic drive_user(input logic [4:0] rs, input logic [4:0] rt, input logic urt);
        drive_idle();
        valid_id = 1'b1; rs_id = rs; rt_id = rt; uses_rt_id = urt;
        write_reg_id = 5'd9; reg_write_id = 1'b1; ctrl_id = 8'h5A;
    endtask

    task automatic test_reset();
        startin = 1'b1; valid_id = 1'b1; rs_id = 5'd7; rt_id = 5'd8; uses_rt_id = 1'b1;
        write_reg_id = 5'd9; data1_id = 32'hDEAD; data2_id = 32'hBEEF; imm_id = 32'h77;
        reg_write_id = 1'b1; mem_read_id = 1'b1; ctrl_id = 8'hFF; wb_reg_write = 1'b1;
        wb_write_reg = 5'd7; wb_write_data = 32'h99; flush = 1'b0;
        tick();
        total++;
        if ({valid_ex, reg_write_ex, mem_read_ex, ctrl_ex, rs_ex, rt_ex, write_reg_ex,
             a_ex, b_ex, imm_ex} !== '0) begin
            bad++; $display("FAIL reset_ex: got a=%h b=%h imm=%h v=%b want all zero", a_ex, b_ex, imm_ex, valid_ex);
        end
        total++;
        if (bubble_cnt !== 16'd0 || s_bubble_cnt !== 2'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d/%0d want 0", bubble_cnt, s_bubble_cnt);
        end
        total++;
        if (stall_out !== 1'b0) begin
            bad++; $display("FAIL reset_stall: got %b want 0", stall_out);
        end
        drive_idle();
    endtask

    task automatic test_normal();
        drive_idle();
        valid_id = 1'b1; rs_id = 5'd3; data1_id = 32'h11; rt_id = 5'd4; data2_id = 32'h22;
        imm_id = 32'hFFFF_FFF0; reg_write_id = 1'b1; write_reg_id = 5'd6; ctrl_id = 8'hA5;
        tick();
        total++;
        if (a_ex !== 32'h11 || b_ex !== 32'h22 || imm_ex !== 32'hFFFF_FFF0) begin
            bad++; $display("FAIL normal_data: got a=%h b=%h imm=%h want 11 22 fffffff0", a_ex, b_ex, imm_ex);
        end
        total++;
        if (valid_ex !== 1'b1 || reg_write_ex !== 1'b1 || mem_read_ex !== 1'b0 ||
            ctrl_ex !== 8'hA5 || rs_ex !== 5'd3 || rt_ex !== 5'd4 || write_reg_ex !== 5'd6) begin
            bad++; $display("FAIL normal_ctrl: got v=%b rw=%b mr=%b c=%h rs=%0d rt=%0d wr=%0d want 1 1 0 a5 3 4 6",
                            valid_ex, reg_write_ex, mem_read_ex, ctrl_ex, rs_ex, rt_ex, write_reg_ex);
        end
        // invalid slot: flags/control forced low but data still captured
        valid_id = 1'b0; mem_read_id = 1'b1; data1_id = 32'h33;
        tick();
        total++;
        if (valid_ex !== 1'b0 || reg_write_ex !== 1'b0 || mem_read_ex !== 1'b0 ||
            ctrl_ex !== 8'h00 || a_ex !== 32'h33) begin
            bad++; $display("FAIL invalid_id: got v=%b rw=%b mr=%b c=%h a=%h want 0 0 0 00 33",
                            valid_ex, reg_write_ex, mem_read_ex, ctrl_ex, a_ex);
        end
        drive_idle();
    endtask

    task automatic test_bypass();
        drive_idle();
        valid_id = 1'b1; rs_id = 5'd5; data1_id = 32'hAAAA; rt_id = 5'd2; data2_id = 32'hBBBB;
        wb_reg_write = 1'b1; wb_write_reg = 5'd5; wb_write_data = 32'h1234;
        tick();
        total++;
        if (a_ex !== 32'h1234 || b_ex !== 32'hBBBB) begin
            bad++; $display("FAIL bypass_a: got a=%h b=%h want 1234 bbbb", a_ex, b_ex);
        end
        rs_id = 5'd0; data1_id = 32'h0; wb_write_reg = 5'd0; rt_id = 5'd0; data2_id = 32'h0;
        tick();
        total++;
        if (a_ex !== 32'h0 || b_ex !== 32'h0) begin
            bad++; $display("FAIL bypass_r0: got a=%h b=%h want 0 0", a_ex, b_ex);
        end
        rs_id = 5'd1; data1_id = 32'h10; rt_id = 5'd7; data2_id = 32'h20; wb_write_reg = 5'd7;
        wb_write_data = 32'hCAFE;
        tick();
        total++;
        if (a_ex !== 32'h10 || b_ex !== 32'hCAFE) begin
            bad++; $display("FAIL bypass_b: got a=%h b=%h want 10 cafe", a_ex, b_ex);
        end
        wb_reg_write = 1'b0;
        tick();
        total++;
        if (b_ex !== 32'h20) begin
            bad++; $display("FAIL bypass_off: got b=%h want 20", b_ex);
        end
        drive_idle();
    endtask

    task automatic test_load_use();
        drive_load(5'd8);
        tick();
        total++;
        if (mem_read_ex !== 1'b1 || write_reg_ex !== 5'd8) begin
            bad++; $display("FAIL lw_capture: got mr=%b wr=%0d want 1 8", mem_read_ex, write_reg_ex);
        end
        drive_user(5'd8, 5'd2, 1'b1);
        #1;
        total++;
        if (stall_out !== 1'b1) begin
            bad++; $display("FAIL lu_stall: got %b want 1", stall_out);
        end
        tick();
        total++;
        if (valid_ex !== 1'b0 || bubble_cnt !== 16'd1) begin
            bad++; $display("FAIL lu_bubble: got v=%b cnt=%0d want 0 1", valid_ex, bubble_cnt);
        end
        total++;
        if (stall_out !== 1'b0) begin
            bad++; $display("FAIL lu_release: got %b want 0", stall_out);
        end
        tick();
        total++;
        if (valid_ex !== 1'b1 || write_reg_ex !== 5'd9 || bubble_cnt !== 16'd1) begin
            bad++; $display("FAIL lu_held: got v=%b wr=%0d cnt=%0d want 1 9 1", valid_ex, write_reg_ex, bubble_cnt);
        end
        drive_load(5'd8);
        tick();
        drive_user(5'd1, 5'd8, 1'b0);
        #1;
        total++;
        if (stall_out !== 1'b0) begin
            bad++; $display("FAIL lu_no_rt: got %b want 0", stall_out);
        end
        tick();
        total++;
        if (valid_ex !== 1'b1 || bubble_cnt !== 16'd1) begin
            bad++; $display("FAIL lu_no_rt_cap: got v=%b cnt=%0d want 1 1", valid_ex, bubble_cnt);
        end
        drive_idle();
    endtask

    task automatic test_flush_hazard();
        drive_load(5'd8);
        tick();
        drive_user(5'd8, 5'd8, 1'b1);
        flush = 1'b1;
        #1;
        total++;
        if (stall_out !== 1'b0) begin
            bad++; $display("FAIL flush_stall: got %b want 0", stall_out);
        end
        tick();
        total++;
        if (valid_ex !== 1'b0 || a_ex !== 32'h0 || write_reg_ex !== 5'd0 || bubble_cnt !== 16'd1) begin
            bad++; $display("FAIL flush_bubble: got v=%b a=%h wr=%0d cnt=%0d want 0 0 0 1",
                            valid_ex, a_ex, write_reg_ex, bubble_cnt);
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_stall();
        drive_load(5'd8);
        tick();
        drive_user(5'd8, 5'd0, 1'b0);
        #1;
        total++;
        if (stall_out !== 1'b1) begin
            bad++; $display("FAIL mid_pre: got %b want 1", stall_out);
        end
        startin = 1'b1;
        #1;
        total++;
        if (stall_out !== 1'b0) begin
            bad++; $display("FAIL mid_drop: got %b want 0", stall_out);
        end
        tick();
        total++;
        if (valid_ex !== 1'b0 || mem_read_ex !== 1'b0 || bubble_cnt !== 16'd0) begin
            bad++; $display("FAIL mid_clear: got v=%b mr=%b cnt=%0d want 0 0 0", valid_ex, mem_read_ex, bubble_cnt);
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_tbl [5];
        exp_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        startin = 1'b1;
        tick();
        drive_idle();
        for (int k = 0; k < 5; k++) begin
            drive_load(5'd12);
            tick();
            drive_user(5'd12, 5'd0, 1'b0);
            tick();
            total++;
            if (s_bubble_cnt !== exp_tbl[k]) begin
                bad++; $display("FAIL sat_%0d: got %0d want %0d", k, s_bubble_cnt, exp_tbl[k]);
            end
        end
        total++;
        if (bubble_cnt !== 16'd5) begin
            bad++; $display("FAIL sat_wide: got %0d want 5", bubble_cnt);
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        #2;
        test_reset();
        test_normal();
        test_bypass();
        test_load_use();
        test_flush_hazard();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
Decode-to-execute pipeline stage that sits directly downstream of the register file. It captures the register-file read data (Data1/Data2), the immediate and the decoded control into the ID/EX pipeline register. It bypasses same-cycle writeback data that the register file cannot yet return. It detects load-use hazards, stalls the front end, inserts bubbles, honours branch flushes, and counts stall bubbles for performance monitoring.

Parameters:
CTRL_W, 8, width of the packed miscellaneous control bundle (ALUSrc, ALUOp, MemWrite, MemToReg, ...)
CNT_W, 16, width of the saturating stall-bubble counter

Ports:
clk  in  1  clock, all state updates on rising edge
startin  in  1  reset, synchronous, active-high
valid_id  in  1  ID holds a real instruction
rs_id  in  5  source register 1 index (Read1)
rt_id  in  5  source register 2 index (Read2)
uses_rt_id  in  1  instruction actually reads rt (0 for I-type ALU/loads)
write_reg_id  in  5  destination register index
data1_id  in  32  register file Data1
data2_id  in  32  register file Data2
imm_id  in  32  sign-extended immediate
reg_write_id  in  1  instruction writes a register
mem_read_id  in  1  instruction is a load
ctrl_id  in  CTRL_W  remaining control bits
wb_reg_write  in  1  writeback stage writes this cycle (the RegWrite into the register file)
wb_write_reg  in  5  writeback destination (WriteReg)
wb_write_data  in  32  writeback data (WriteData)
flush  in  1  branch/jump taken; kill the ID instruction
stall_out  out  1  hold PC and IF/ID this cycle
valid_ex, reg_write_ex, mem_read_ex  out  1 each  registered ID/EX flags
ctrl_ex  out  CTRL_W  registered control
rs_ex, rt_ex, write_reg_ex  out  5 each  registered indices (used by EX forwarding)
a_ex, b_ex, imm_ex  out  32 each  registered operands
bubble_cnt  out  CNT_W  count of load-use bubbles inserted

Behaviour:
- Reset: on a rising edge with startin=1, every registered output and bubble_cnt go to 0. stall_out is 0 whenever startin=1.
- Latency: 1 cycle from ID inputs to *_ex outputs.
- WB bypass (combinational, before capture): a_next = wb_write_data if wb_reg_write && wb_write_reg!=0 && wb_write_reg==rs_id; otherwise a_next = data1_id. b_next is the same rule using rt_id and data2_id. r0 is never bypassed. This covers the register file's write-at-edge / read-async gap.
- Hazard (combinational): hz = valid_ex && mem_read_ex && write_reg_ex!=0 && valid_id && (write_reg_ex==rs_id || (uses_rt_id && write_reg_ex==rt_id)).
- stall_out = hz && !flush && !startin.
- Edge priority: startin > flush > hz > normal load.
  - flush: capture a bubble. All *_ex outputs = 0, bubble_cnt unchanged.
  - hz (no flush): capture a bubble (same zeros), bubble_cnt += 1. The ID instruction is held upstream by stall_out.
  - normal: capture all ID fields with a_next/b_next. If valid_id=0, force valid_ex, reg_write_ex, mem_read_ex and ctrl_ex to 0; data fields are still captured.
- After a hz bubble, valid_ex=0, so hz clears. A load-use stall is therefore exactly 1 cycle.
- bubble_cnt saturates at all-ones and never wraps.
- Bubble and normal captures do not depend on wb_*; the bypass applies only to captured data.
- Reset asserted mid-stall: outputs clear, stall_out drops in the same cycle.

Test Plan:
1. Reset: drive nonzero values on all inputs, startin=1 for one edge. All *_ex=0, bubble_cnt=0, stall_out=0.
2. Normal capture: valid_id=1, rs_id=3, data1_id=0x11, rt_id=4, data2_id=0x22, imm_id=0xFFFFFFF0, reg_write_id=1. Next edge: a_ex=0x11, b_ex=0x22, imm_ex=0xFFFFFFF0, valid_ex=1, reg_write_ex=1.
3. WB bypass: rs_id=5, data1_id=0xAAAA, wb_reg_write=1, wb_write_reg=5, wb_write_data=0x1234 gives a_ex=0x1234. Repeat with rs_id=0, wb_write_reg=0, data1_id=0 gives a_ex=0.
4. Load-use: lw writing r8 captured (mem_read_ex=1, write_reg_ex=8). Next cycle rs_id=8 gives stall_out=1. Next edge: valid_ex=0, bubble_cnt=1. Following cycle: stall_out=0 and the held instruction captures with valid_ex=1. With uses_rt_id=0 and only rt_id=8, there is no stall.
5. Flush plus hazard in the same cycle: stall_out=0, bubble captured, bubble_cnt unchanged.
6. Saturation: with CNT_W=2, force 5 load-use stalls. bubble_cnt reads 1, 2, 3, 3, 3.
